// File: rtl/ddr4_phy_pkg.sv
// Shared definitions for the DDR4 PHY fabric-side lane controllers.
package ddr4_phy_pkg;

    // FAB_CLK to tCK gearing: four tCK slots per fabric cycle.
    localparam int FAB_TCK_RATIO = 4;

    // Default ODT timing in tCK.
    localparam int DEF_ODTL_CK    = 9;
    localparam int DEF_ODT_LEN_CK = 6;
    localparam int DEF_TL_W       = 32;
    localparam int DEF_MOVE_GAP   = 4;

    // Delay-line trim sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETDIR = 3'd2,
        ST_MOVE   = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } trim_state_e;

endpackage

// File: rtl/ddr4_delay_trim_fsm.sv
// Delay-line trim sequencer for the ODT IOD: load, or direction set followed
// by a train of move pulses spaced move_gap cycles apart, with abort on the
// IOD out-of-range flag.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a trim request
// LOAD   | one-cycle load pulse (reload default delay)
// SETDIR | direction presented one cycle ahead of the first move
// MOVE   | one-cycle move pulse, remaining step count decremented
// GAP    | move_gap-1 cycles of spacing; out-of-range aborts here
// DONE   | one-cycle completion pulse
module ddr4_delay_trim_fsm
    import ddr4_phy_pkg::*;
#(
    parameter int MOVE_GAP = DEF_MOVE_GAP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trim_req,
    input  logic       trim_load,
    input  logic       trim_dir,
    input  logic [7:0] trim_steps,
    input  logic       out_of_range,
    output logic       trim_done,
    output logic       trim_err,
    output logic       dl_move,
    output logic       dl_direction,
    output logic       dl_load
);

    localparam int GAP_W = (MOVE_GAP > 2) ? $clog2(MOVE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MOVE_GAP - 2);

    trim_state_e      state;
    trim_state_e      state_nxt;
    logic [7:0]       steps_q;
    logic [7:0]       steps_nxt;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_nxt;
    logic             dir_q;
    logic             dir_nxt;
    logic             err_q;
    logic             err_nxt;

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            steps_q <= '0;
            gap_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            steps_q <= steps_nxt;
            gap_q   <= gap_nxt;
            dir_q   <= dir_nxt;
            err_q   <= err_nxt;
        end
    end

    // Next-state and datapath updates; pulses are decoded from the state.
    always_comb begin
        state_nxt = state;
        steps_nxt = steps_q;
        gap_nxt   = gap_q;
        dir_nxt   = dir_q;
        err_nxt   = err_q;
        case (state)
            ST_IDLE: begin
                if (trim_req) begin
                    err_nxt = 1'b0;
                    if (trim_load) begin
                        state_nxt = ST_LOAD;
                    end else begin
                        state_nxt = ST_SETDIR;
                        dir_nxt   = trim_dir;
                        steps_nxt = trim_steps;
                    end
                end
            end
            ST_LOAD: begin
                state_nxt = ST_DONE;
            end
            ST_SETDIR: begin
                state_nxt = (steps_q == 8'd0) ? ST_DONE : ST_MOVE;
            end
            ST_MOVE: begin
                steps_nxt = steps_q - 8'd1;
                gap_nxt   = GAP_RELOAD;
                state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (out_of_range) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (gap_q == '0) begin
                    state_nxt = (steps_q == 8'd0) ? ST_DONE : ST_MOVE;
                end else begin
                    gap_nxt = gap_q - GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Moore outputs straight from the state register.
    always_comb begin
        dl_move      = (state == ST_MOVE);
        dl_load      = (state == ST_LOAD);
        trim_done    = (state == ST_DONE);
        dl_direction = dir_q;
        trim_err     = err_q;
    end

endmodule

// File: rtl/ddr4_odt_lane_ctrl.sv
// DDR4 ODT lane controller: turns write commands into a tCK-resolution ODT
// waveform (four tCK per FAB_CLK, bit 0 first) on a shifting timeline, and
// hosts the delay-line trim sequencer for the same IOD.
module ddr4_odt_lane_ctrl
    import ddr4_phy_pkg::*;
#(
    parameter int ODTL_CK    = DEF_ODTL_CK,
    parameter int ODT_LEN_CK = DEF_ODT_LEN_CK,
    parameter int TL_W       = DEF_TL_W,
    parameter int MOVE_GAP   = DEF_MOVE_GAP
) (
    input  logic       FAB_CLK,
    input  logic       TX_SYNC_RST,
    input  logic       ENABLE,
    input  logic       WR_VALID,
    input  logic [1:0] WR_SLOT,
    output logic [3:0] TX_DATA_0,
    output logic [3:0] OE_DATA_0,
    output logic       ODT_EN_0,
    input  logic       TRIM_REQ,
    input  logic       TRIM_LOAD,
    input  logic       TRIM_DIR,
    input  logic [7:0] TRIM_STEPS,
    output logic       TRIM_DONE,
    output logic       TRIM_ERR,
    output logic       DELAY_LINE_MOVE_0,
    output logic       DELAY_LINE_DIRECTION_0,
    output logic       DELAY_LINE_LOAD_0,
    input  logic       DELAY_LINE_OUT_OF_RANGE_0
);

    // The latest window end (slot 3) plus one spare tCK must fit the timeline.
    if (ODTL_CK + ODT_LEN_CK + 3 > TL_W) begin : g_tl_too_small
        $error("ddr4_odt_lane_ctrl: TL_W too small for ODTL_CK + ODT_LEN_CK");
    end
    if (MOVE_GAP < 2) begin : g_gap_too_small
        $error("ddr4_odt_lane_ctrl: MOVE_GAP must be at least 2");
    end

    logic [TL_W-1:0] tl;
    logic [TL_W-1:0] mask;
    logic [TL_W-1:0] merged;
    int              win_lo;

    // Window mask for a command issued this cycle, positioned in tCK.
    always_comb begin
        mask   = '0;
        win_lo = int'(WR_SLOT) + ODTL_CK;
        if (ENABLE && WR_VALID) begin
            for (int k = 0; k < TL_W; k++) begin
                mask[k] = (k >= win_lo) && (k < win_lo + ODT_LEN_CK);
            end
        end
        merged = tl | mask;
    end

    // Timeline shift: emit the four oldest tCK, advance by one fabric cycle.
    always_ff @(posedge FAB_CLK) begin
        if (TX_SYNC_RST || !ENABLE) begin
            tl        <= '0;
            TX_DATA_0 <= '0;
            OE_DATA_0 <= '0;
        end else begin
            tl        <= merged >> FAB_TCK_RATIO;
            TX_DATA_0 <= merged[FAB_TCK_RATIO-1:0];
            OE_DATA_0 <= 4'b1111;
        end
    end

    // Output-only pin: input termination never enabled.
    always_comb begin
        ODT_EN_0 = 1'b0;
    end

    ddr4_delay_trim_fsm #(
        .MOVE_GAP (MOVE_GAP)
    ) u_trim (
        .clk          (FAB_CLK),
        .rst          (TX_SYNC_RST),
        .trim_req     (TRIM_REQ),
        .trim_load    (TRIM_LOAD),
        .trim_dir     (TRIM_DIR),
        .trim_steps   (TRIM_STEPS),
        .out_of_range (DELAY_LINE_OUT_OF_RANGE_0),
        .trim_done    (TRIM_DONE),
        .trim_err     (TRIM_ERR),
        .dl_move      (DELAY_LINE_MOVE_0),
        .dl_direction (DELAY_LINE_DIRECTION_0),
        .dl_load      (DELAY_LINE_LOAD_0)
    );

endmodule

// File: doc/ddr4_odt_lane_ctrl.md
# ddr4_odt_lane_ctrl

Fabric-side driver for the DDR4 ODT output IOD. It converts write commands from the memory controller into a 4-bit-per-FAB_CLK ODT waveform at tCK resolution (1:4 gearing), holding the output enable. Overlapping write windows merge into one continuous assertion. It also runs the dynamic delay-line trim handshake (load, move and direction, with out-of-range abort) for the IOD.

## Interface
Parameters:
- ODTL_CK, 9: ODT assertion latency from command tCK, in tCK.
- ODT_LEN_CK, 6: ODT window length in tCK (BL8 plus pre/postamble).
- TL_W, 32: timeline register width in tCK. Must satisfy ODTL_CK+ODT_LEN_CK+3 ≤ TL_W; elaboration-time assertion.
- MOVE_GAP, 4: FAB_CLK cycles between successive delay-line move pulses (≥2).

Ports:
- FAB_CLK  in  1  fabric clock; the only clock.
- TX_SYNC_RST  in  1  synchronous, active-high reset.
- ENABLE  in  1  ODT path enable.
- WR_VALID  in  1  write command issued this cycle.
- WR_SLOT  in  2  tCK slot (0..3) of the command within this FAB_CLK cycle.
- TX_DATA_0  out  4  ODT bits to IOD; bit 0 is transmitted first.
- OE_DATA_0  out  4  output enable to IOD.
- ODT_EN_0  out  1  IOD input termination; constant 0 (output-only pin).
- TRIM_REQ  in  1  start trim operation (accepted only in IDLE).
- TRIM_LOAD  in  1  with TRIM_REQ: reload the default delay instead of moving.
- TRIM_DIR  in  1  move direction (1 = increment).
- TRIM_STEPS  in  8  number of move steps (0 = immediate done).
- TRIM_DONE  out  1  one-cycle pulse at trim completion or abort.
- TRIM_ERR  out  1  sticky out-of-range flag; cleared by the next accepted TRIM_REQ or by reset.
- DELAY_LINE_MOVE_0  out  1  move pulse to IOD.
- DELAY_LINE_DIRECTION_0  out  1  direction to IOD.
- DELAY_LINE_LOAD_0  out  1  load pulse to IOD.
- DELAY_LINE_OUT_OF_RANGE_0  in  1  IOD range flag.

## Operation
- Timeline TL[TL_W-1:0]: bit k is tCK k relative to tCK 0 of the current cycle.
- On WR_VALID && ENABLE, the mask sets bits WR_SLOT+ODTL_CK through WR_SLOT+ODTL_CK+ODT_LEN_CK-1. Otherwise the mask is 0.
- Each cycle: M = TL | mask; TX_DATA_0 <= M[3:0]; TL <= M >> 4, zero-filled.
- Overlapping or adjacent windows OR together, giving no gap.
- ENABLE low: TL cleared, TX_DATA_0 = 0, OE_DATA_0 = 0, commands ignored. ENABLE high: OE_DATA_0 = 4'b1111, registered.
- Trim FSM states: IDLE, LOAD, SETDIR, MOVE, GAP, DONE.
  - IDLE + TRIM_REQ + TRIM_LOAD → LOAD.
  - IDLE + TRIM_REQ + !TRIM_LOAD → SETDIR; TRIM_DIR and TRIM_STEPS are captured and TRIM_ERR is cleared.
  - LOAD: DELAY_LINE_LOAD_0 = 1 for one cycle → DONE.
  - SETDIR: DELAY_LINE_DIRECTION_0 driven from the captured value; it stays stable until the next SETDIR. If steps = 0 → DONE, else → MOVE.
  - MOVE: DELAY_LINE_MOVE_0 = 1 for one cycle; step count decrements → GAP.
  - GAP: waits MOVE_GAP-1 cycles.
    - If DELAY_LINE_OUT_OF_RANGE_0 is sampled high in any GAP cycle: TRIM_ERR set → DONE (abort).
    - Otherwise, if count = 0 → DONE, else → MOVE.
  - DONE: TRIM_DONE = 1 for one cycle → IDLE.
- TRIM_REQ outside IDLE is ignored.
- Trim operation is independent of ENABLE and of ODT traffic.

## Timing
- Reset values: TX_DATA_0 = 0, OE_DATA_0 = 0, ODT_EN_0 = 0, all DELAY_LINE_* = 0, TRIM_DONE = 0, TRIM_ERR = 0, TL = 0, FSM = IDLE.
- Command in cycle n: tCK t = s+ODTL_CK appears in TX_DATA_0[t mod 4] in cycle n+1+floor(t/4). The fixed one-cycle register offset is absorbed by the controller's latency.
- Reset mid-window: the ODT window is dropped immediately; no partial tail.
- Reset mid-trim: no further pulses, and no TRIM_DONE is issued.
- Move pulses are spaced exactly MOVE_GAP cycles apart. Direction is stable at least one cycle before the first pulse.
- Trim latency for N>0 steps without error: DONE pulse at 2 + N·MOVE_GAP cycles after acceptance.

## Structure
- Shared package ddr4_phy_pkg holds:
  - trim FSM state enum;
  - the FAB_CLK-to-tCK ratio constant (4);
  - default ODTL/length constants.
- Sub-module ddr4_delay_trim_fsm holds the trim FSM. The timeline logic stays in the top level.

## Test plan
- Reset, ENABLE=1, no commands → OE_DATA_0 = 4'b1111 from the cycle after ENABLE; TX_DATA_0 = 0 every cycle.
- ODTL_CK=9, LEN=6, one command at cycle 0, slot 0 → TX_DATA_0 = 0 in cycles 1–2, 4'b1110 in cycle 3, 4'b0111 in cycle 4, 0 after.
- Commands at cycle 0 slot 0 and cycle 1 slot 2 → 4'b1110, 4'b1111, 4'b1111, 4'b0001 in cycles 3–6; no gap.
- TRIM_REQ with DIR=1, STEPS=3, MOVE_GAP=4 → DIRECTION high from cycle 1, MOVE pulses in cycles 2, 6, 10, TRIM_DONE in cycle 14, TRIM_ERR = 0.
- Same request with OUT_OF_RANGE forced high after the second pulse → exactly 2 MOVE pulses, then TRIM_DONE, TRIM_ERR = 1; it clears on the next request.
- TX_SYNC_RST asserted during an active window and mid-trim → all outputs 0 the next cycle; no DONE pulse; the FSM restarts in IDLE.
